// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port among N_REQ requesters
//   (e.g. ALU writeback, load unit, move unit). Round-robin arbitration
//   with a req/gnt handshake and registered write-port outputs.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   reset     - asynchronous, active-high reset
//   req       - per-requester write request (level)
//   req_addr  - packed destination addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  - packed write data, requester i at [i*WIDTH +: WIDTH]
//   hold      - pipeline stall, blocks new grants while high
//   gnt       - one-hot grant, registered, one-cycle pulse
//   wr_en     - register-file write enable, registered
//   wr_addr   - register-file write address, registered
//   wr_data   - register-file write data, registered
//   busy      - some eligible request is not being granted this cycle
module rf_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  input  logic                      hold,
  output logic [N_REQ-1:0]          gnt,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [WIDTH-1:0]          wr_data,
  output logic                      busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   N_EXT    = (PTR_W+1)'(N_REQ);

  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [WIDTH-1:0]  wr_data_reg;
  logic [PTR_W-1:0]  ptr_reg, ptr_next;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [WIDTH-1:0]  data_arr [N_REQ];

  logic [N_REQ-1:0]  elig;
  logic              win_found;
  logic [PTR_W-1:0]  win_idx;
  logic              grant_now;

  // Unpack the per-requester address/data slices.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The requester holding the current grant is masked so a req that is
  // still high for one more cycle is not written twice.
  assign elig = req & ~gnt_reg;

  // Scan offsets from highest to lowest so the lowest offset from ptr
  // (the highest-priority eligible requester) is the last assignment.
  // The sum is one bit wider so the wrap is at N_REQ, not 2**PTR_W.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int o = N_REQ - 1; o >= 0; o--) begin
      sum = {1'b0, ptr_reg} + (PTR_W+1)'(o);
      if (sum >= N_EXT) begin
        sum = sum - N_EXT;
      end
      cand = sum[PTR_W-1:0];
      if (elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant_now = win_found && !hold;

  always_comb begin
    gnt_next = '0;
    ptr_next = ptr_reg;
    if (grant_now) begin
      gnt_next[win_idx] = 1'b1;
      ptr_next = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
    end
  end

  // Anything eligible that is not the one being granted is left waiting.
  assign busy = |(elig & ~gnt_next);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      ptr_reg     <= '0;
    end else begin
      gnt_reg   <= gnt_next;
      wr_en_reg <= grant_now;
      ptr_reg   <= ptr_next;
      // Address/data hold their last value when nothing is granted.
      if (grant_now) begin
        wr_addr_reg <= addr_arr[win_idx];
        wr_data_reg <= data_arr[win_idx];
      end
    end
  end

  assign gnt     = gnt_reg;
  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Table of per-cycle stimulus records with hand-derived expectations;
//   expected outputs are queued when stimulus is driven and compared when
//   the registered outputs appear. A second instance with N_REQ=3 covers
//   the non-power-of-two pointer wrap. Reset-during-grant is a hand sequence.
module tb_rf_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic        hold;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;

  logic [2:0]  req3;
  logic [8:0]  req_addr3;
  logic [47:0] req_data3;
  logic        hold3;
  logic [2:0]  gnt3;
  logic        wr_en3;
  logic [2:0]  wr_addr3;
  logic [15:0] wr_data3;
  logic        busy3;

  rf_write_arbiter #(.N_REQ(4), .WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .req_data(req_data), .hold(hold), .gnt(gnt), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  rf_write_arbiter #(.N_REQ(3), .WIDTH(16), .ADDR_W(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_addr(req_addr3),
    .req_data(req_data3), .hold(hold3), .gnt(gnt3), .wr_en(wr_en3),
    .wr_addr(wr_addr3), .wr_data(wr_data3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file behind the write port, used for the conflict readback.
  logic [15:0] rf [8];
  always @(posedge clk) begin
    if (wr_en) rf[wr_addr] <= wr_data;
  end

  typedef struct {
    string       name;
    logic [3:0]  req;
    logic [11:0] addr;
    logic [63:0] data;
    logic        hold;
    logic        exp_busy;
    logic [3:0]  exp_gnt;
    logic        exp_en;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    string       name;
    logic [3:0]  gnt;
    logic        en;
    logic [2:0]  addr;
    logic [15:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Default requester i: address i+1, data 16'hD000+i.
  function automatic vec_t mk(string name, logic [3:0] r, logic h, logic b,
                              logic [3:0] g, logic e, logic [2:0] a, logic [15:0] d);
    vec_t v;
    v.name = name; v.req = r; v.hold = h; v.exp_busy = b;
    v.exp_gnt = g; v.exp_en = e; v.exp_addr = a; v.exp_data = d;
    v.addr = {3'd4, 3'd3, 3'd2, 3'd1};
    v.data = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    chk({e.name, "/gnt"},     32'(gnt),     32'(e.gnt));
    chk({e.name, "/wr_en"},   32'(wr_en),   32'(e.en));
    chk({e.name, "/wr_addr"}, 32'(wr_addr), 32'(e.addr));
    chk({e.name, "/wr_data"}, 32'(wr_data), 32'(e.data));
  endtask

  // One cycle: drive inputs, check combinational busy, queue the expected
  // registered outputs, then compare them just after the next rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    req = v.req; req_addr = v.addr; req_data = v.data; hold = v.hold;
    #1;
    chk({v.name, "/busy"}, 32'(busy), 32'(v.exp_busy));
    e.name = v.name; e.gnt = v.exp_gnt; e.en = v.exp_en;
    e.addr = v.exp_addr; e.data = v.exp_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(e);
    $display("vec %-10s req=%b hold=%b -> gnt=%b wr_en=%b addr=%0d data=%h busy=%b",
             v.name, v.req, v.hold, gnt, wr_en, wr_addr, wr_data, busy);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    logic [2:0] exp3_gnt [4];
    logic [2:0] exp3_addr [4];

    reset = 1'b1; req = '0; req_addr = '0; req_data = '0; hold = 1'b0;
    req3 = '0; req_addr3 = {3'd3, 3'd2, 3'd1};
    req_data3 = {16'hE002, 16'hE001, 16'hE000}; hold3 = 1'b0;

    // ---------------- reset state ----------------
    #12;
    e.name = "reset"; e.gnt = 4'b0000; e.en = 1'b0; e.addr = 3'd0; e.data = 16'h0000;
    check_outputs(e);
    chk("reset/busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- stimulus table ----------------
    // round robin, all requesters, each drops for one cycle after its grant
    vecs.push_back(mk("rr0",   4'b1111, 0, 1, 4'b0001, 1, 3'd1, 16'hD000));
    vecs.push_back(mk("rr1",   4'b1110, 0, 1, 4'b0010, 1, 3'd2, 16'hD001));
    vecs.push_back(mk("rr2",   4'b1101, 0, 1, 4'b0100, 1, 3'd3, 16'hD002));
    vecs.push_back(mk("rr3",   4'b1011, 0, 1, 4'b1000, 1, 3'd4, 16'hD003));
    vecs.push_back(mk("rr4",   4'b0111, 0, 1, 4'b0001, 1, 3'd1, 16'hD000));
    vecs.push_back(mk("idle0", 4'b0000, 0, 0, 4'b0000, 0, 3'd1, 16'hD000));
    // single request (ptr=1 here), then masked while req[2] stays high
    v = mk("single",  4'b0100, 0, 0, 4'b0100, 1, 3'd5, 16'hBEEF);
    v.addr[8:6] = 3'd5; v.data[47:32] = 16'hBEEF; vecs.push_back(v);
    v = mk("masked",  4'b0100, 0, 0, 4'b0000, 0, 3'd5, 16'hBEEF);
    v.addr[8:6] = 3'd5; v.data[47:32] = 16'hBEEF; vecs.push_back(v);
    // wrap from ptr=3 to requester 0, then skip to 2
    vecs.push_back(mk("wrap0", 4'b0101, 0, 1, 4'b0001, 1, 3'd1, 16'hD000));
    vecs.push_back(mk("wrap1", 4'b0101, 0, 0, 4'b0100, 1, 3'd3, 16'hD002));
    // hold for three cycles, ptr stays 3, then grant wraps to 0
    vecs.push_back(mk("hold0", 4'b0011, 1, 1, 4'b0000, 0, 3'd3, 16'hD002));
    vecs.push_back(mk("hold1", 4'b0011, 1, 1, 4'b0000, 0, 3'd3, 16'hD002));
    vecs.push_back(mk("hold2", 4'b0011, 1, 1, 4'b0000, 0, 3'd3, 16'hD002));
    vecs.push_back(mk("unhold",4'b0011, 0, 1, 4'b0001, 1, 3'd1, 16'hD000));
    vecs.push_back(mk("after", 4'b0010, 0, 0, 4'b0010, 1, 3'd2, 16'hD001));
    vecs.push_back(mk("idle1", 4'b0000, 0, 0, 4'b0000, 0, 3'd2, 16'hD001));
    // bring ptr to 0 via a lone grant to requester 3
    vecs.push_back(mk("r3",    4'b1000, 0, 0, 4'b1000, 1, 3'd4, 16'hD003));
    vecs.push_back(mk("idle2", 4'b0000, 0, 0, 4'b0000, 0, 3'd4, 16'hD003));
    // same-address conflict: requester 0 then 3, later write wins
    v = mk("conf0", 4'b1001, 0, 1, 4'b0001, 1, 3'd7, 16'h0001);
    v.addr[2:0] = 3'd7; v.addr[11:9] = 3'd7; v.data[15:0] = 16'h0001; v.data[63:48] = 16'h0003;
    vecs.push_back(v);
    v = mk("conf1", 4'b1000, 0, 0, 4'b1000, 1, 3'd7, 16'h0003);
    v.addr[2:0] = 3'd7; v.addr[11:9] = 3'd7; v.data[15:0] = 16'h0001; v.data[63:48] = 16'h0003;
    vecs.push_back(v);
    vecs.push_back(mk("conf2", 4'b0000, 0, 0, 4'b0000, 0, 3'd7, 16'h0003));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end
    chk("conf/rf7", 32'(rf[7]), 32'h0003);

    // ---------------- N_REQ=3 wrap ----------------
    exp3_gnt[0] = 3'b001; exp3_gnt[1] = 3'b010; exp3_gnt[2] = 3'b100; exp3_gnt[3] = 3'b001;
    exp3_addr[0] = 3'd1;  exp3_addr[1] = 3'd2;  exp3_addr[2] = 3'd3;  exp3_addr[3] = 3'd1;
    req3 = 3'b111;
    #1;
    chk("n3/busy", 32'(busy3), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("n3_%0d/gnt", i),     32'(gnt3),     32'(exp3_gnt[i]));
      chk($sformatf("n3_%0d/wr_en", i),   32'(wr_en3),   32'd1);
      chk($sformatf("n3_%0d/wr_addr", i), 32'(wr_addr3), 32'(exp3_addr[i]));
      $display("n3 cycle %0d -> gnt=%b wr_en=%b addr=%0d data=%h",
               i, gnt3, wr_en3, wr_addr3, wr_data3);
    end
    req3 = '0;

    // ---------------- reset during a grant ----------------
    v = mk("rst", 4'b0010, 0, 0, 4'b0000, 0, 3'd0, 16'h0000);
    req = v.req; req_addr = v.addr; req_data = v.data; hold = 1'b0;
    @(posedge clk);
    #1;
    e.name = "rst_pre"; e.gnt = 4'b0010; e.en = 1'b1; e.addr = 3'd2; e.data = 16'hD001;
    check_outputs(e);
    #3;
    reset = 1'b1;
    #1;
    e.name = "rst_mid"; e.gnt = 4'b0000; e.en = 1'b0; e.addr = 3'd0; e.data = 16'h0000;
    check_outputs(e);
    $display("reset mid-cycle -> gnt=%b wr_en=%b addr=%0d", gnt, wr_en, wr_addr);
    @(posedge clk);
    #1;
    e.name = "rst_held";
    check_outputs(e);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    e.name = "rst_regnt"; e.gnt = 4'b0010; e.en = 1'b1; e.addr = 3'd2; e.data = 16'hD001;
    check_outputs(e);
    $display("after reset -> gnt=%b wr_en=%b addr=%0d data=%h", gnt, wr_en, wr_addr, wr_data);
    req = 4'b0000;
    @(posedge clk);
    #1;
    e.name = "rst_done"; e.gnt = 4'b0000; e.en = 1'b0;
    check_outputs(e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
